pokey_keyboard_ctrl: RTL
========================

Name: pokey_keyboard_ctrl

Overview:
CPU-facing controller and sequencer for the POKEY keyboard scanner. It decodes the keyboard-related POKEY registers: SKCTL and IRQEN on write, KBCODE, IRQST and SKSTAT on read, and SKRES as a write strobe. It generates the scanner's line-rate enable tick, holds the scanner in init mode when requested, and latches the break and other-key interrupts into a single active-low IRQ line.

Parameters:
SCAN_DIV, 114, number of clk cycles per scan tick (114 gives 15.7 kHz from 1.79 MHz)
CNT_W, 7, prescaler counter width; must satisfy 2^CNT_W >= SCAN_DIV

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
addr  in  4  POKEY register address
wr_en  in  1  one-cycle write strobe
rd_en  in  1  one-cycle read strobe
data_in  in  8  write data
data_out  out  8  registered read data
scan_tick  out  1  one-cycle pulse to scanner enable
scan_enable  out  1  to scanner scan_enable
debounce_disable  out  1  to scanner debounce_disable
key_held  in  1  from scanner
shift_held  in  1  from scanner
keycode  in  8  from scanner
other_key_irq  in  1  one-cycle pulse from scanner
break_irq  in  1  one-cycle pulse from scanner
irq_n  out  1  active-low interrupt request

Behaviour:
- Reset values:
  - skctl_reg = 0x00, irqen_reg = 0x00, pending[7:6] = 00, overrun = 0.
  - Prescaler = 0, state = INIT, data_out = 0xFF, scan_tick = 0, irq_n = 1, scan_enable = 0, debounce_disable = 1.
- Register map:
  - Write 0xF: SKCTL.
  - Write 0xE: IRQEN.
  - Write 0xA: SKRES strobe (no data stored).
  - Read 0x9: KBCODE.
  - Read 0xE: IRQST.
  - Read 0xF: SKSTAT.
  - All other addresses: reads return 0xFF and writes are ignored.
- Read latency: data_out updates on the clk edge that samples rd_en and is held until the next read.
- Read data:
  - KBCODE returns keycode.
  - IRQST = {~pending[7], ~pending[6], 6'b111111}.
  - SKSTAT = {2'b11, ~overrun, 1'b1, ~shift_held, ~key_held, 2'b11}.
- Scanner control outputs: scan_enable = skctl_reg[1] and state==RUN; debounce_disable = ~skctl_reg[0]. Both are combinational from registers.
- State machine, two states (INIT, RUN):
  - INIT: prescaler held at 0; scan_tick = 0.
  - INIT to RUN: on an SKCTL write with data_in[1:0] != 00, effective the next cycle.
  - RUN to INIT: on an SKCTL write with data_in[1:0] == 00; the prescaler clears on the same edge.
- Prescaler in RUN:
  - Counts 0 to SCAN_DIV-1 and wraps.
  - scan_tick is registered and asserted for exactly one cycle when the count wraps.
  - The first tick arrives SCAN_DIV cycles after entering RUN.
  - An SKCTL write that stays in RUN does not restart the prescaler.
- Interrupt latching:
  - break_irq sets pending[7] if irqen_reg[7] = 1.
  - other_key_irq sets pending[6] if irqen_reg[6] = 1.
  - An IRQEN write stores data_in; any bit written 0 clears the matching pending bit.
  - A clear takes precedence over a set in the same cycle.
  - The set condition uses irqen_reg (the old value).
- irq_n = ~|(pending[7:6] & irqen_reg[7:6]), registered with one cycle of latency.
- Reset asserted mid-operation aborts the scan tick immediately and returns all values to their reset state.

Optional Feature:
Macro POKEY_KBD_OVERRUN_EN.
- Defined:
  - other_key_irq while pending[6] is already 1 sets overrun.
  - An SKRES write clears overrun.
  - A set and a clear in the same cycle leave overrun = 1.
- Undefined: the overrun register is absent and SKSTAT bit5 reads 1 permanently; SKRES writes are ignored.

Decomposition:
- Package pokey_kbd_pkg holds:
  - address localparams ADDR_KBCODE = 4'h9, ADDR_SKRES = 4'hA, ADDR_IRQ = 4'hE, ADDR_SK = 4'hF;
  - IRQ bit indices IRQ_BREAK = 7, IRQ_KEY = 6;
  - the state enum {ST_INIT, ST_RUN}.
- One sub-module, pokey_scan_prescaler (clk, reset_n, run, clear, tick), is natural. The register and IRQ logic stay in the top level.

Test Plan:
- Reset, then read 0xF and 0xE: data_out = 0xFF for both; scan_tick stays 0 for 1000 cycles.
- Write SKCTL = 0x03: scan_enable = 1, debounce_disable = 0, first scan_tick 114 cycles later, then every 114 cycles; write SKCTL = 0x00: ticks stop the next cycle.
- IRQEN = 0x40, then an other_key_irq pulse: irq_n = 0 one cycle later and IRQST reads 0xBF; write IRQEN = 0x00: irq_n = 1 and IRQST reads 0xFF.
- IRQEN = 0x80 and break_irq in the same cycle as an IRQEN = 0x00 write: pending stays 0 and irq_n stays 1.
- Overrun with the macro defined: IRQEN = 0x40, two other_key_irq pulses: SKSTAT bit5 = 0; SKRES write: bit5 = 1. With the macro undefined, bit5 stays 1.
- key_held = 1, shift_held = 1, keycode = 0x5A: SKSTAT reads 0xF3 and KBCODE reads 0x5A.

Source files
------------

// File: rtl/pokey_kbd_pkg.sv
// pokey_kbd_pkg: shared register addresses, IRQ bit positions and sequencer states
// for the POKEY keyboard controller.
package pokey_kbd_pkg;
    localparam logic [3:0] ADDR_KBCODE = 4'h9;
    localparam logic [3:0] ADDR_SKRES  = 4'hA;
    localparam logic [3:0] ADDR_IRQ    = 4'hE;
    localparam logic [3:0] ADDR_SK     = 4'hF;
    localparam int IRQ_BREAK = 7;
    localparam int IRQ_KEY   = 6;
    typedef enum logic {ST_INIT, ST_RUN} state_t;
endpackage

// File: rtl/pokey_scan_prescaler.sv
// pokey_scan_prescaler: divides clk by SCAN_DIV into a registered one-cycle scan tick;
// held at zero while not running or when cleared.
module pokey_scan_prescaler #(
    parameter int SCAN_DIV = 114,
    parameter int CNT_W    = 7
) (
    input  logic clk,
    input  logic reset_n,
    input  logic run,
    input  logic clear,
    output logic tick
);
    logic [CNT_W-1:0] cnt;
    logic             wrap;

    assign wrap = cnt == CNT_W'(SCAN_DIV - 1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (clear || !run) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            cnt  <= wrap ? '0 : cnt + CNT_W'(1);
            tick <= wrap;
        end
    end
endmodule

// File: rtl/pokey_keyboard_ctrl.sv
// pokey_keyboard_ctrl: CPU register decode, scan sequencing and IRQ latching for the
// POKEY keyboard scanner. Define POKEY_KBD_OVERRUN_EN to add the SKSTAT overrun flag.
module pokey_keyboard_ctrl
    import pokey_kbd_pkg::*;
#(
    parameter int SCAN_DIV = 114,
    parameter int CNT_W    = 7
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] addr,
    input  logic       wr_en,
    input  logic       rd_en,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       scan_tick,
    output logic       scan_enable,
    output logic       debounce_disable,
    input  logic       key_held,
    input  logic       shift_held,
    input  logic [7:0] keycode,
    input  logic       other_key_irq,
    input  logic       break_irq,
    output logic       irq_n
);
    state_t      state, state_nx;
    logic [7:0]  skctl_reg, irqen_reg, rd_data;
    logic [7:6]  pending, pending_nx;
    logic        sk_wr, sk_off, irq_wr, overrun;

    assign sk_wr  = wr_en && addr == ADDR_SK;
    assign sk_off = sk_wr && data_in[1:0] == 2'b00;
    assign irq_wr = wr_en && addr == ADDR_IRQ;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_INIT;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (state == ST_INIT && sk_wr && !sk_off) state_nx = ST_RUN;
        if (state == ST_RUN && sk_off)            state_nx = ST_INIT;
    end

    pokey_scan_prescaler #(.SCAN_DIV(SCAN_DIV), .CNT_W(CNT_W)) u_prescaler (
        .clk    (clk),
        .reset_n(reset_n),
        .run    (state == ST_RUN),
        .clear  (sk_off),
        .tick   (scan_tick)
    );

    assign scan_enable      = skctl_reg[1] && state == ST_RUN;
    assign debounce_disable = ~skctl_reg[0];

    // Sets are gated by the enable mask before this cycle's write; a zero written clears and wins.
    always_comb begin
        pending_nx = pending | {break_irq & irqen_reg[IRQ_BREAK], other_key_irq & irqen_reg[IRQ_KEY]};
        if (irq_wr) pending_nx = pending_nx & data_in[7:6];
    end

`ifdef POKEY_KBD_OVERRUN_EN
    logic skres_wr;
    assign skres_wr = wr_en && addr == ADDR_SKRES;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                                  overrun <= 1'b0;
        else if (other_key_irq && pending[IRQ_KEY])    overrun <= 1'b1;
        else if (skres_wr)                             overrun <= 1'b0;
    end
`else
    assign overrun = 1'b0;
`endif

    always_comb begin
        rd_data = addr == ADDR_KBCODE ? keycode :
                  addr == ADDR_IRQ    ? {~pending, 6'b111111} :
                  addr == ADDR_SK     ? {2'b11, ~overrun, 1'b1, ~shift_held, ~key_held, 2'b11} :
                                        8'hFF;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            skctl_reg <= 8'h00;
            irqen_reg <= 8'h00;
            pending   <= 2'b00;
            data_out  <= 8'hFF;
            irq_n     <= 1'b1;
        end else begin
            if (sk_wr)  skctl_reg <= data_in;
            if (irq_wr) irqen_reg <= data_in;
            if (rd_en)  data_out  <= rd_data;
            pending <= pending_nx;
            irq_n   <= ~|(pending & irqen_reg[7:6]);
        end
    end
endmodule
